// File: rtl/systolic_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_seq
// Function : Issues ctrl words, weight addresses and activation reads for one
//            pass of a systolic_cell chain, drains the pipeline, pulses done.
// Revision : 1.0  initial release
// ============================================================================
module systolic_array_seq #(
    parameter int CTRL_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 8,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      start,
    input  logic                      abort,
    input  logic [MEM_ADDR_WIDTH:0]   cfg_taps,
    input  logic [CNT_WIDTH-1:0]      cfg_outs,
    output logic [CTRL_WIDTH-1:0]     ctrl_out,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
    output logic                      x_rd_en,
    output logic [CNT_WIDTH-1:0]      x_rd_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam int c_dw = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_dw-1:0]         c_drain_init = c_dw'(DRAIN_CYCLES);
    localparam logic [c_dw-1:0]         c_drain_one  = c_dw'(1);
    localparam logic [MEM_ADDR_WIDTH:0] c_max_taps   = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};
    localparam logic [MEM_ADDR_WIDTH:0] c_taps_one   = (MEM_ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_WIDTH-1:0]    c_outs_one   = CNT_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_t_one    = MEM_ADDR_WIDTH'(1);

    logic [1:0]                r_state, w_state;
    logic [MEM_ADDR_WIDTH-1:0] r_taps_m1, w_taps_m1;
    logic [CNT_WIDTH-1:0]      r_outs_m1, w_outs_m1;
    logic [MEM_ADDR_WIDTH-1:0] r_t, w_t;
    logic [CNT_WIDTH-1:0]      r_o, w_o;
    logic [c_dw-1:0]           r_drain, w_drain;

    logic [CTRL_WIDTH-1:0]     w_ctrl;
    logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
    logic                      w_x_rd_en;
    logic [CNT_WIDTH-1:0]      w_x_rd_addr;
    logic                      w_busy, w_done, w_cfg_err;
    logic                      w_cfg_ok, w_last;
    logic [7:0]                w_o_byte;

    // The ctrl word carries the low byte of the output index.
    if (CNT_WIDTH >= 8) begin : g_obyte_wide
        assign w_o_byte = r_o[7:0];
    end else begin : g_obyte_narrow
        assign w_o_byte = {{(8 - CNT_WIDTH){1'b0}}, r_o};
    end

    assign w_cfg_ok = (cfg_taps != '0) && (cfg_taps <= c_max_taps) && (cfg_outs != '0);
    assign w_last   = (r_t == r_taps_m1);

    always_comb begin
        w_state     = r_state;
        w_taps_m1   = r_taps_m1;
        w_outs_m1   = r_outs_m1;
        w_t         = r_t;
        w_o         = r_o;
        w_drain     = r_drain;
        w_ctrl      = '0;
        w_mem_addr  = '0;
        w_x_rd_en   = 1'b0;
        w_x_rd_addr = '0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_cfg_err   = 1'b0;
        case (r_state)
            c_st_idle: begin
                // abort beats a coincident start
                if (start && !abort) begin
                    if (w_cfg_ok) begin
                        w_taps_m1 = MEM_ADDR_WIDTH'(cfg_taps - c_taps_one);
                        w_outs_m1 = cfg_outs - c_outs_one;
                        w_t       = '0;
                        w_o       = '0;
                        w_state   = c_st_run;
                        w_busy    = 1'b1;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            c_st_run: begin
                if (abort) begin
                    w_state = c_st_idle;
                end else begin
                    w_busy           = 1'b1;
                    w_mem_addr       = r_t;
                    w_x_rd_en        = 1'b1;
                    w_x_rd_addr      = r_o + CNT_WIDTH'(r_t);
                    w_ctrl[0]        = (r_t == '0);
                    w_ctrl[1]        = 1'b1;
                    w_ctrl[2]        = w_last;
                    w_ctrl[15:8]     = w_o_byte;
                    if (w_last) begin
                        w_t = '0;
                        if (r_o == r_outs_m1) begin
                            w_state = c_st_drain;
                            w_drain = c_drain_init;
                        end else begin
                            w_o = r_o + c_outs_one;
                        end
                    end else begin
                        w_t = r_t + c_t_one;
                    end
                end
            end
            c_st_drain: begin
                if (abort) begin
                    w_state = c_st_idle;
                end else begin
                    w_busy  = 1'b1;
                    w_drain = r_drain - c_drain_one;
                    if (r_drain == c_drain_one) begin
                        w_state = c_st_done;
                    end
                end
            end
            c_st_done: begin
                w_done  = 1'b1;
                w_state = c_st_idle;
            end
            default: w_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_taps_m1    <= '0;
            r_outs_m1    <= '0;
            r_t          <= '0;
            r_o          <= '0;
            r_drain      <= '0;
            ctrl_out     <= '0;
            mem_addr_out <= '0;
            x_rd_en      <= 1'b0;
            x_rd_addr    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else if (ce) begin
            r_state      <= w_state;
            r_taps_m1    <= w_taps_m1;
            r_outs_m1    <= w_outs_m1;
            r_t          <= w_t;
            r_o          <= w_o;
            r_drain      <= w_drain;
            ctrl_out     <= w_ctrl;
            mem_addr_out <= w_mem_addr;
            x_rd_en      <= w_x_rd_en;
            x_rd_addr    <= w_x_rd_addr;
            busy         <= w_busy;
            done         <= w_done;
            cfg_err      <= w_cfg_err;
        end
    end

endmodule
`default_nettype wire

// File: doc/systolic_array_seq.md
Name: systolic_array_seq

Overview:
Sequencer that drives the control, weight-address and activation-fetch streams of a systolic_cell chain for one convolution/dense pass.
- Takes a start command with a tap count and an output count.
- Emits the per-cycle ctrl word and weight ROM address into the head cell of the chain.
- Issues activation-buffer read addresses, waits for the pipeline to drain, then pulses done.
- Sits between the layer-level controller and the systolic array.

Parameters:
CTRL_WIDTH, 32, width of the ctrl word fed to the cell chain
MEM_ADDR_WIDTH, 4, weight ROM address width; the maximum tap count is 2^MEM_ADDR_WIDTH
CNT_WIDTH, 8, width of the output counter and of the activation read address
DRAIN_CYCLES, 4, cycles to wait after the last MAC issue (equals array depth)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ce  input  1  clock enable; when low all state, counters and outputs hold
start  input  1  single-cycle command strobe, sampled in IDLE only
abort  input  1  synchronous cancel of the current pass
cfg_taps  input  MEM_ADDR_WIDTH+1  taps per output, valid range 1..2^MEM_ADDR_WIDTH
cfg_outs  input  CNT_WIDTH  number of outputs, valid range 1..2^CNT_WIDTH-1
ctrl_out  output  CTRL_WIDTH  ctrl word driven to the head cell's ctrl_in
mem_addr_out  output  MEM_ADDR_WIDTH  weight address driven to the head cell's mem_addr_in
x_rd_en  output  1  activation buffer read enable
x_rd_addr  output  CNT_WIDTH  activation buffer read address
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
cfg_err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Output timing: all outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- ce=0 freezes everything: start and abort are not sampled and no pulse is lost or duplicated.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with cfg_taps in 1..2^MEM_ADDR_WIDTH and cfg_outs≥1: latch cfg, clear counters t=0 and o=0, go to RUN, busy=1.
  - start with cfg_taps=0, cfg_taps>2^MEM_ADDR_WIDTH, or cfg_outs=0: stay in IDLE, cfg_err=1 for one cycle, busy stays 0.
- RUN: one MAC issue per enabled cycle.
  - mem_addr_out=t.
  - x_rd_en=1, x_rd_addr=o+t (stride-1 window; wraps modulo 2^CNT_WIDTH).
  - ctrl_out[0]=first (t==0, accumulator load).
  - ctrl_out[1]=mac_en=1.
  - ctrl_out[2]=last (t==taps-1).
  - ctrl_out[15:8]=o[7:0].
  - All other ctrl_out bits are 0.
  - Counter update: t increments; at t==taps-1, t→0 and o increments.
  - At t==taps-1 and o==outs-1: go to DRAIN, load drain counter with DRAIN_CYCLES.
- DRAIN: ctrl_out=0, x_rd_en=0, mem_addr_out=0. Decrement the counter each cycle; at 1 go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- Timing: start sampled at edge E0.
  - RUN issues appear on edges E1..ET, where T=taps·outs.
  - Drain occupies ET+1..ET+DRAIN_CYCLES.
  - done is high after edge ET+DRAIN_CYCLES+1.
  - A new start may be accepted in the cycle done is high; the FSM is then in IDLE.
- start while busy: ignored, no error pulse.
- abort (sampled when ce=1) in RUN or DRAIN: next edge goes to IDLE, all outputs 0, no done. Abort in IDLE has no effect.
- abort and start together in IDLE: abort wins, start is dropped.
- Reset asserted mid-pass: all outputs are 0 immediately (asynchronous); after deassert the block is in IDLE.
- taps=1: first and last are both set on every issue.

Test Plan:
1. Basic pass:
   - Stimulus: rst pulse, then start with taps=3, outs=2, ce=1.
   - Required: 6 issues; mem_addr 0,1,2,0,1,2; x_rd_addr 0,1,2,1,2,3; ctrl_out[0] on issues 1 and 4; ctrl_out[2] on issues 3 and 6; ctrl_out[15:8] 0,0,0,1,1,1; done pulses exactly 11 cycles after the start edge (6+4+1).
2. Bad configuration:
   - Stimulus: start with taps=0; then start with taps=17 (MEM_ADDR_WIDTH=4); then start with outs=0.
   - Required: cfg_err pulses once for each start, busy never rises, no issue occurs.
3. Stall handling:
   - Stimulus: taps=4, outs=1, ce=0 for 3 cycles after the second issue.
   - Required: outputs hold their values during the stall; sequence 0,1,2,3 completes; done comes 3 cycles later than the unstalled case.
4. Abort:
   - Stimulus: abort during the third issue of a taps=4, outs=4 pass; then a fresh start with taps=2, outs=1.
   - Required: IDLE next cycle, all outputs 0, no done; the fresh start runs cleanly from t=0, o=0.
5. Reset and busy-start:
   - Stimulus: rst asserted mid-RUN without a clock edge; separately, start pulsed while busy.
   - Required: outputs are 0 asynchronously; after release the next start behaves as scenario 1; the start while busy is ignored and cfg_err stays 0.
6. Edge values:
   - Stimulus: taps=1, outs=255.
   - Required: ctrl_out[0] and ctrl_out[2] high on every issue; x_rd_addr 0..254; done after 260 cycles.
